// File: rtl/out_mem_responder.sv
// Memory-side responder for the shared PE output bus: takes one burst header per grant and
// services each beat against a banked SRAM port, returning tagged read data to the cores.
module out_mem_responder #(
  parameter int NUM_CORES      = 4,
  parameter int CORE_BIT_WIDTH = $clog2(NUM_CORES),
  parameter int BURST_WIDTH    = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = CORE_BIT_WIDTH + ADDR_WIDTH
) (
  input  logic                      w_clock,
  input  logic                      w_reset,
  input  logic [NUM_CORES-1:0]      w_grant,
  input  logic                      w_hdr_valid,
  input  logic [BURST_WIDTH-1:0]    w_burst,
  input  logic                      w_beat_valid,
  input  logic                      w_rw,
  input  logic [ADDR_WIDTH-1:0]     w_addr,
  input  logic [DATA_WIDTH-1:0]     w_wdata,
  output logic                      r_mem_en,
  output logic                      r_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] r_mem_addr,
  output logic [DATA_WIDTH-1:0]     r_mem_wdata,
  input  logic [DATA_WIDTH-1:0]     w_mem_rdata,
  output logic [DATA_WIDTH-1:0]     r_rdata,
  output logic                      r_rdata_valid,
  output logic [NUM_CORES-1:0]      r_rdata_dst,
  output logic                      r_busy,
  output logic                      r_done,
  output logic                      r_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]                r_state, state_d;
  logic [CORE_BIT_WIDTH-1:0] r_sel, sel_d;
  logic [BURST_WIDTH-1:0]    r_len, len_d;
  logic [BURST_WIDTH:0]      r_cnt, cnt_d;
  logic                      r_dir, dir_d;
  logic                      r_dir_set, dir_set_d;
  logic                      issue, err_d, done_d;

  // Read return pipeline: stage a is the SRAM command cycle, stage b the SRAM data cycle.
  logic [NUM_CORES-1:0]      r_dst_a, r_dst_b;
  logic                      r_rd_b;
  logic                      rd_a;

  logic                      grant_onehot;
  logic [CORE_BIT_WIDTH-1:0] grant_idx;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_grant[i]) grant_idx = CORE_BIT_WIDTH'(i);
    end
  end

  assign grant_onehot = (w_grant != '0) && ((w_grant & (w_grant - NUM_CORES'(1))) == '0);
  assign rd_a         = r_mem_en && !r_mem_we;
  assign r_busy       = (r_state != IDLE);

  always_comb begin
    state_d   = r_state;
    sel_d     = r_sel;
    len_d     = r_len;
    cnt_d     = r_cnt;
    dir_d     = r_dir;
    dir_set_d = r_dir_set;
    issue     = 1'b0;
    err_d     = 1'b0;
    done_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hdr_valid) begin
          if (grant_onehot) begin
            sel_d     = grant_idx;
            len_d     = w_burst;
            cnt_d     = '0;
            dir_d     = 1'b0;
            dir_set_d = 1'b0;
            state_d   = ACTIVE;
          end else begin
            err_d = 1'b1;
          end
        end
        if (w_beat_valid) err_d = 1'b1;
      end
      ACTIVE: begin
        if (!w_grant[r_sel]) begin
          // Grant withdrawn: abort; reads already issued still drain through the pipeline.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (w_hdr_valid) err_d = 1'b1;
          if (w_beat_valid) begin
            if (r_dir_set && (w_rw != r_dir)) begin
              err_d = 1'b1;
            end else begin
              issue     = 1'b1;
              dir_d     = w_rw;
              dir_set_d = 1'b1;
              cnt_d     = r_cnt + (BURST_WIDTH + 1)'(1);
              if (r_cnt == {1'b0, r_len}) begin
                if (w_rw) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                end else begin
                  state_d = DRAIN;
                end
              end
            end
          end
        end
      end
      DRAIN: begin
        if (w_hdr_valid || w_beat_valid) err_d = 1'b1;
        // Final read is the one in the data stage with nothing left in the command stage.
        if (r_rd_b && !rd_a) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_state       <= IDLE;
      r_sel         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_dir         <= 1'b0;
      r_dir_set     <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_dst_a       <= '0;
      r_dst_b       <= '0;
      r_rd_b        <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_rdata_dst   <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= state_d;
      r_sel         <= sel_d;
      r_len         <= len_d;
      r_cnt         <= cnt_d;
      r_dir         <= dir_d;
      r_dir_set     <= dir_set_d;
      r_mem_en      <= issue;
      r_mem_we      <= issue & w_rw;
      if (issue) begin
        r_mem_addr  <= {r_sel, w_addr};
        r_mem_wdata <= w_wdata;
      end
      r_dst_a       <= (issue && !w_rw) ? (NUM_CORES'(1) << r_sel) : '0;
      r_dst_b       <= r_dst_a;
      r_rd_b        <= rd_a;
      r_rdata_valid <= r_rd_b;
      r_rdata_dst   <= r_rd_b ? r_dst_b : '0;
      if (r_rd_b) r_rdata <= w_mem_rdata;
      r_done        <= done_d;
      r_err         <= err_d;
    end
  end

endmodule
